// File: rtl/line_follow_pid.sv
// N-channel line follower: hysteresis thresholding, position error, saturating PID
// and lost-line search/stop, as a 4-stage pipeline advanced by sample_valid tokens.
module line_follow_pid #(
    parameter int N_SENS      = 3,
    parameter int ADC_W       = 12,
    parameter int HYST        = 8,
    parameter int DUTY_W      = 8,
    parameter int I_MAX       = 30,
    parameter int SEARCH_DUTY = 40,
    parameter int LOST_LIMIT  = 200
) (
    input  logic                      clk_50,
    input  logic                      reset,
    input  logic                      sample_valid,
    input  logic [N_SENS*ADC_W-1:0]   sens_data,
    input  logic [ADC_W-1:0]          thr,
    input  logic [DUTY_W-1:0]         base_duty,
    input  logic [7:0]                kp,
    input  logic [7:0]                ki,
    input  logic [7:0]                kd,
    output logic [N_SENS-1:0]         line_bits,
    output logic signed [3:0]         error,
    output logic [1:0]                state,
    output logic [DUTY_W-1:0]         duty_left,
    output logic [DUTY_W-1:0]         duty_right,
    output logic                      out_valid
);

    localparam int LOST_W = $clog2(LOST_LIMIT + 1);
    localparam logic signed [15:0] I_MAX_S    = 16'(I_MAX);
    localparam logic signed [25:0] DUTY_MAX_S = 26'(2**DUTY_W - 1);
    localparam logic signed [25:0] SEARCH_S   = 26'(SEARCH_DUTY);

    typedef enum logic [1:0] {
        ST_TRACK  = 2'b00,
        ST_SEARCH = 2'b01,
        ST_STOP   = 2'b10
    } state_e;

    // Handshake: a token enters when sample_valid is high on a rising edge and
    // leaves as a single out_valid pulse four edges later; there is no backpressure.

    // ---------------- stage 1: hysteresis ----------------
    logic [N_SENS-1:0] line_bits_q, bits_d;
    logic              v1_q;
    logic [DUTY_W-1:0] base1_q;
    logic [7:0]        kp1_q, ki1_q, kd1_q;
    logic [ADC_W:0]    hi_sum;
    logic [ADC_W-1:0]  hi_thr, lo_thr, ch;

    always_comb begin
        hi_sum = {1'b0, thr} + (ADC_W+1)'(HYST);
        hi_thr = hi_sum[ADC_W] ? '1 : hi_sum[ADC_W-1:0];
        lo_thr = (thr < ADC_W'(HYST)) ? '0 : thr - ADC_W'(HYST);
        bits_d = line_bits_q;
        ch     = '0;
        for (int i = 0; i < N_SENS; i++) begin
            ch = sens_data[i*ADC_W +: ADC_W];
            if (ch > hi_thr)      bits_d[i] = 1'b1;
            else if (ch < lo_thr) bits_d[i] = 1'b0;
        end
    end

    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            line_bits_q <= '0;
            v1_q        <= 1'b0;
            base1_q     <= '0;
            kp1_q       <= '0;
            ki1_q       <= '0;
            kd1_q       <= '0;
        end else begin
            v1_q <= sample_valid;
            if (sample_valid) begin
                line_bits_q <= bits_d;
                base1_q     <= base_duty;
                kp1_q       <= kp;
                ki1_q       <= ki;
                kd1_q       <= kd;
            end
        end
    end

    // ---------------- stage 2: error, FSM, integral, derivative ----------------
    state_e              state_q, state_d;
    logic signed [3:0]   error_q, error_d, prev_q, prev_d, err_calc;
    logic signed [15:0]  integ_q, integ_d, integ_sum;
    logic signed [4:0]   deriv_q, deriv_d;
    logic [LOST_W-1:0]   lost_q, lost_d, lost_inc;
    logic                neg_q, neg_d, any_set, all_set, v2_q;
    logic [3:0]          lo_idx, hi_idx;
    logic [DUTY_W-1:0]   base2_q;
    logic [7:0]          kp2_q, ki2_q, kd2_q;

    always_comb begin
        any_set = |line_bits_q;
        all_set = &line_bits_q;
        lo_idx  = '0;
        hi_idx  = '0;
        for (int i = N_SENS - 1; i >= 0; i--)
            if (line_bits_q[i]) lo_idx = 4'(i);
        for (int i = 0; i < N_SENS; i++)
            if (line_bits_q[i]) hi_idx = 4'(i);
        err_calc  = lo_idx + hi_idx - 4'(N_SENS - 1);
        integ_sum = integ_q + 16'(err_calc);
        lost_inc  = lost_q + 1'b1;
    end

    always_comb begin
        state_d = state_q;
        error_d = error_q;
        integ_d = integ_q;
        prev_d  = prev_q;
        deriv_d = deriv_q;
        lost_d  = lost_q;
        neg_d   = neg_q;
        if (v1_q) begin
            if (!any_set) begin
                error_d = '0;
                deriv_d = '0;
                case (state_q)
                    ST_TRACK: begin
                        state_d = ST_SEARCH;
                        integ_d = '0;
                        lost_d  = LOST_W'(1);
                    end
                    ST_SEARCH: begin
                        lost_d = lost_inc;
                        if (lost_inc == LOST_W'(LOST_LIMIT)) state_d = ST_STOP;
                    end
                    default: state_d = ST_STOP;
                endcase
            end else begin
                state_d = ST_TRACK;
                error_d = err_calc;
                // A junction (all sensors set) must not wind up the integrator.
                if (!all_set) begin
                    if (integ_sum > I_MAX_S)       integ_d = I_MAX_S;
                    else if (integ_sum < -I_MAX_S) integ_d = -I_MAX_S;
                    else                           integ_d = integ_sum;
                end
                if (state_q == ST_TRACK) begin
                    deriv_d = 5'(err_calc) - 5'(prev_q);
                    prev_d  = err_calc;
                end else begin
                    deriv_d = '0;
                    prev_d  = '0;
                    lost_d  = '0;
                end
                if (err_calc != 4'sd0) neg_d = err_calc[3];
            end
        end
    end

    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            state_q <= ST_STOP;
            error_q <= '0;
            integ_q <= '0;
            prev_q  <= '0;
            deriv_q <= '0;
            lost_q  <= '0;
            neg_q   <= 1'b0;
            v2_q    <= 1'b0;
            base2_q <= '0;
            kp2_q   <= '0;
            ki2_q   <= '0;
            kd2_q   <= '0;
        end else begin
            state_q <= state_d;
            error_q <= error_d;
            integ_q <= integ_d;
            prev_q  <= prev_d;
            deriv_q <= deriv_d;
            lost_q  <= lost_d;
            neg_q   <= neg_d;
            v2_q    <= v1_q;
            if (v1_q) begin
                base2_q <= base1_q;
                kp2_q   <= kp1_q;
                ki2_q   <= ki1_q;
                kd2_q   <= kd1_q;
            end
        end
    end

    // ---------------- stage 3: PID sum ----------------
    logic signed [23:0] delta_q, delta_d;
    state_e             st3_q;
    logic               neg3_q, v3_q;
    logic [DUTY_W-1:0]  base3_q;

    always_comb begin
        delta_d = 24'($signed({1'b0, kp2_q})) * 24'(error_q)
                + 24'($signed({1'b0, ki2_q})) * 24'(integ_q)
                + 24'($signed({1'b0, kd2_q})) * 24'(deriv_q);
    end

    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            delta_q <= '0;
            st3_q   <= ST_STOP;
            neg3_q  <= 1'b0;
            base3_q <= '0;
            v3_q    <= 1'b0;
        end else begin
            v3_q <= v2_q;
            if (v2_q) begin
                delta_q <= delta_d;
                st3_q   <= state_q;
                neg3_q  <= neg_q;
                base3_q <= base2_q;
            end
        end
    end

    // ---------------- stage 4: duty words ----------------
    function automatic logic [DUTY_W-1:0] sat_duty(input logic signed [25:0] v);
        if (v < 26'sd0)           return '0;
        else if (v > DUTY_MAX_S)  return '1;
        else                      return v[DUTY_W-1:0];
    endfunction

    logic [DUTY_W-1:0]  duty_l_q, duty_r_q, duty_l_d, duty_r_d, fast_d, slow_d;
    logic signed [25:0] b_ext, d_ext;
    logic               ov_q;

    always_comb begin
        b_ext    = 26'($signed({1'b0, base3_q}));
        d_ext    = 26'(delta_q);
        fast_d   = sat_duty(b_ext + SEARCH_S);
        slow_d   = sat_duty(b_ext - SEARCH_S);
        duty_l_d = '0;
        duty_r_d = '0;
        case (st3_q)
            ST_TRACK: begin
                duty_l_d = sat_duty(b_ext + d_ext);
                duty_r_d = sat_duty(b_ext - d_ext);
            end
            // Positive (or never-set) last error means the line is to the right.
            ST_SEARCH: begin
                duty_l_d = neg3_q ? slow_d : fast_d;
                duty_r_d = neg3_q ? fast_d : slow_d;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            duty_l_q <= '0;
            duty_r_q <= '0;
            ov_q     <= 1'b0;
        end else begin
            ov_q <= v3_q;
            if (v3_q) begin
                duty_l_q <= duty_l_d;
                duty_r_q <= duty_r_d;
            end
        end
    end

    assign line_bits  = line_bits_q;
    assign error      = error_q;
    assign state      = state_q;
    assign duty_left  = duty_l_q;
    assign duty_right = duty_r_q;
    assign out_valid  = ov_q;

endmodule

// File: tb/tb_line_follow_pid.sv
// Directed + randomized bench for line_follow_pid (N_SENS=3) against a behavioural model.
module tb_line_follow_pid;

    localparam int N      = 3;
    localparam int HYST   = 8;
    localparam int I_MAX  = 30;
    localparam int SD     = 40;
    localparam int LOST   = 200;
    localparam int DMAX   = 255;
    localparam int AMAX   = 4095;

    logic              clk_50 = 1'b0;
    logic              reset;
    logic              sample_valid;
    logic [35:0]       sens_data;
    logic [11:0]       thr;
    logic [7:0]        base_duty, kp, ki, kd;
    logic [2:0]        line_bits;
    logic signed [3:0] error;
    logic [1:0]        state;
    logic [7:0]        duty_left, duty_right;
    logic              out_valid;

    line_follow_pid dut (
        .clk_50(clk_50), .reset(reset), .sample_valid(sample_valid),
        .sens_data(sens_data), .thr(thr), .base_duty(base_duty),
        .kp(kp), .ki(ki), .kd(kd), .line_bits(line_bits), .error(error),
        .state(state), .duty_left(duty_left), .duty_right(duty_right),
        .out_valid(out_valid)
    );

    always #10 clk_50 = ~clk_50;

    int tests = 0;
    int fails = 0;
    logic [15:0] obs_q[$];
    logic [15:0] exp_q[$];

    always @(negedge clk_50)
        if (out_valid === 1'b1) obs_q.push_back({duty_left, duty_right});

    // model state and per-sample expectations
    int g_thr, g_base, g_kp, g_ki, g_kd;
    int m_bits[N];
    int m_state, m_integ, m_prev, m_lost;
    bit m_neg;
    int e_bits, e_err, e_state, e_dl, e_dr;

    function automatic int clampi(int v, int lo, int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    task automatic model_reset();
        foreach (m_bits[i]) m_bits[i] = 0;
        m_state = 2; m_integ = 0; m_prev = 0; m_lost = 0; m_neg = 0;
    endtask

    task automatic model_step(input int a, input int b, input int c);
        int d[N];
        int set_q[$];
        int hi, lo, deriv, delta;
        d = '{a, b, c};
        hi = clampi(g_thr + HYST, 0, AMAX);
        lo = clampi(g_thr - HYST, 0, AMAX);
        e_bits = 0;
        deriv = 0;
        for (int i = 0; i < N; i++) begin
            if (d[i] > hi) m_bits[i] = 1;
            else if (d[i] < lo) m_bits[i] = 0;
            if (m_bits[i] == 1) begin
                set_q.push_back(i);
                e_bits += (1 << i);
            end
        end
        if (set_q.size() == 0) begin
            e_err = 0;
            if (m_state == 0) begin
                m_state = 1; m_integ = 0; m_lost = 1;
            end else if (m_state == 1) begin
                m_lost++;
                if (m_lost == LOST) m_state = 2;
            end
        end else begin
            e_err = set_q[0] + set_q[set_q.size()-1] - (N - 1);
            if (set_q.size() != N) m_integ = clampi(m_integ + e_err, -I_MAX, I_MAX);
            if (m_state == 0) begin
                deriv = e_err - m_prev;
                m_prev = e_err;
            end else begin
                m_prev = 0; m_lost = 0;
            end
            m_state = 0;
            if (e_err != 0) m_neg = (e_err < 0);
        end
        e_state = m_state;
        if (m_state == 0) begin
            delta = g_kp * e_err + g_ki * m_integ + g_kd * deriv;
            e_dl = clampi(g_base + delta, 0, DMAX);
            e_dr = clampi(g_base - delta, 0, DMAX);
        end else if (m_state == 1) begin
            e_dl = m_neg ? clampi(g_base - SD, 0, DMAX) : clampi(g_base + SD, 0, DMAX);
            e_dr = m_neg ? clampi(g_base + SD, 0, DMAX) : clampi(g_base - SD, 0, DMAX);
        end else begin
            e_dl = 0; e_dr = 0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic scramble();
        sens_data = 36'({$urandom(), $urandom()});
        thr       = 12'($urandom());
        base_duty = 8'($urandom());
        kp        = 8'($urandom());
        ki        = 8'($urandom());
        kd        = 8'($urandom());
    endtask

    task automatic drive_sample(input int a, input int b, input int c);
        @(negedge clk_50);
        thr = 12'(g_thr); base_duty = 8'(g_base);
        kp = 8'(g_kp); ki = 8'(g_ki); kd = 8'(g_kd);
        sens_data = {12'(c), 12'(b), 12'(a)};
        sample_valid = 1'b1;
        model_step(a, b, c);
    endtask

    // one isolated sample, checked at every pipeline stage
    task automatic step(input int a, input int b, input int c);
        drive_sample(a, b, c);
        @(negedge clk_50);
        sample_valid = 1'b0;
        scramble();
        chk("line_bits", 32'(line_bits), 32'(e_bits));
        chk("ov_t1", 32'(out_valid), 0);
        @(negedge clk_50);
        chk("error", 32'(error), 32'(e_err));
        chk("state", 32'(state), 32'(e_state));
        @(negedge clk_50);
        chk("ov_t3", 32'(out_valid), 0);
        @(negedge clk_50);
        chk("ov_t4", 32'(out_valid), 1);
        chk("duty_left", 32'(duty_left), 32'(e_dl));
        chk("duty_right", 32'(duty_right), 32'(e_dr));
        @(negedge clk_50);
        chk("ov_t5", 32'(out_valid), 0);
    endtask

    function automatic int rnd_ch();
        case ($urandom_range(0, 3))
            0:       return int'($urandom_range(0, 300));
            1:       return int'($urandom_range(300, 360));
            default: return int'($urandom_range(360, 4095));
        endcase
    endfunction

    task automatic rnd_cfg();
        case ($urandom_range(0, 5))
            0:       g_thr = int'($urandom_range(0, 10));
            1:       g_thr = int'($urandom_range(4085, 4095));
            default: g_thr = 330;
        endcase
        g_base = int'($urandom_range(0, 255));
        g_kp = int'($urandom_range(0, 30));
        g_ki = int'($urandom_range(0, 8));
        g_kd = int'($urandom_range(0, 30));
    endtask

    // back-to-back strobes with per-sample gains, duties compared in order
    task automatic burst(input int n);
        obs_q.delete();
        exp_q.delete();
        for (int k = 0; k < n; k++) begin
            rnd_cfg();
            drive_sample(rnd_ch(), rnd_ch(), rnd_ch());
            exp_q.push_back({8'(e_dl), 8'(e_dr)});
        end
        @(negedge clk_50);
        sample_valid = 1'b0;
        scramble();
        repeat (8) @(negedge clk_50);
        chk("burst_count", 32'(obs_q.size()), 32'(n));
        while (obs_q.size() > 0 && exp_q.size() > 0)
            chk("burst_duties", 32'(obs_q.pop_front()), 32'(exp_q.pop_front()));
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_bits"}, 32'(line_bits), 0);
        chk({tag, "_err"}, 32'(error), 0);
        chk({tag, "_state"}, 32'(state), 2);
        chk({tag, "_dl"}, 32'(duty_left), 0);
        chk({tag, "_dr"}, 32'(duty_right), 0);
        chk({tag, "_ov"}, 32'(out_valid), 0);
    endtask

    initial begin
        reset = 1'b1;
        sample_valid = 1'b0;
        scramble();
        model_reset();
        repeat (3) @(negedge clk_50);
        chk_idle("reset");
        reset = 1'b0;
        @(negedge clk_50);
        chk_idle("post_reset");

        g_thr = 330; g_base = 60; g_kp = 4; g_ki = 0; g_kd = 0;
        step(100, 500, 100);
        step(100, 500, 500);
        step(100, 100, 500);
        // hysteresis on channel 1
        step(100, 500, 100);
        step(100, 335, 100);
        step(100, 321, 100);
        step(100, 335, 100);
        // integral saturation
        g_kp = 0; g_ki = 1; g_kd = 0;
        for (int i = 0; i < 20; i++) step(100, 100, 500);
        g_base = 250; g_kp = 20; g_ki = 0;
        step(100, 100, 500);
        // search then stop
        g_base = 60; g_kp = 4; g_kd = 3;
        step(100, 500, 500);
        for (int i = 0; i < LOST; i++) step(100, 100, 100);
        step(100, 500, 100);
        step(500, 500, 500);
        step(500, 100, 100);
        step(100, 100, 100);

        for (int i = 0; i < 40; i++) begin
            rnd_cfg();
            step(rnd_ch(), rnd_ch(), rnd_ch());
        end
        burst(6);
        burst(5);

        // reset while a token is in flight
        obs_q.delete();
        g_thr = 330; g_base = 60; g_kp = 4; g_ki = 0; g_kd = 0;
        drive_sample(100, 500, 500);
        @(negedge clk_50);
        sample_valid = 1'b0;
        @(negedge clk_50);
        reset = 1'b1;
        model_reset();
        @(negedge clk_50);
        chk_idle("mid_reset");
        reset = 1'b0;
        repeat (6) @(negedge clk_50);
        chk("mid_reset_no_ov", 32'(obs_q.size()), 0);
        chk_idle("after_mid_reset");
        step(100, 500, 100);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
